// File: rtl/div_fsm_pkg.sv
// Shared ALU definitions for the restoring divider: FSM state encoding and
// the field layout of the packed result word.
package div_fsm_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_ITER  = 2'd2;
  localparam logic [1:0] ST_SAVE  = 2'd3;

  // Result layout for the default 8-bit operand width.
  localparam int DIV_N    = 8;
  localparam int QUOT_LSB = 0;
  localparam int REM_LSB  = DIV_N;
  localparam int DBZ_BIT  = 2 * DIV_N;
  localparam int ID_LSB   = 2 * DIV_N + 1;

  function automatic int result_width(input int n, input int id_w);
    return 2 * n + 1 + id_w;
  endfunction

endpackage

// File: rtl/div_fsm_div_step.sv
// One combinational restoring-division step: shift {A,Q} left, trial-subtract
// the divisor from A, keep the difference and set the quotient bit if it fits.
module div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] q,
  input  logic [N-1:0] m,
  output logic [N:0]   a_nxt,
  output logic [N-1:0] q_nxt
);

  function automatic logic signed [N+2:0] add_sub(
    input logic signed [N+2:0] x,
    input logic signed [N+2:0] y,
    input logic                sub
  );
    return sub ? (x - y) : (x + y);
  endfunction

  logic        [N+1:0] a_sh;
  logic signed [N+2:0] trial;

  always_comb begin
    a_sh  = {a, q[N-1]};
    trial = add_sub($signed({1'b0, a_sh}), $signed({3'b000, m}), 1'b1);
    a_nxt = a_sh[N:0];
    q_nxt = {q[N-2:0], 1'b0};
    if (trial >= 0) begin
      a_nxt = trial[N:0];
      q_nxt = {q[N-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_fsm.sv
// Sequential restoring divider: accepts an operand pair from the input FIFO,
// runs one trial-subtract step per cycle and holds the result for the result FIFO.
module div_fsm
  import div_fsm_pkg::*;
#(
  parameter int DATA_SIZE     = 16,
  parameter int DIV_DATA_SIZE = DATA_SIZE / 2,
  parameter int ID_SIZE       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DIV_DATA_SIZE-1:0]     a_in,
  input  logic [DIV_DATA_SIZE-1:0]     b_in,
  input  logic [ID_SIZE-1:0]           id_div,
  input  logic                         d_valid_data,
  input  logic                         ready_f_res,
  input  logic                         div_written,
  output logic                         d_ready_data,
  output logic                         d_valid_res,
  output logic [DATA_SIZE+ID_SIZE:0]   result_div,
  output logic                         start
);

  localparam int N     = DIV_DATA_SIZE;
  localparam int CNT_W = $clog2(N + 1);

  logic [1:0]         state;
  logic [N:0]         a_reg;
  logic [N-1:0]       q_reg;
  logic [N-1:0]       m_reg;
  logic [ID_SIZE-1:0] id_reg;
  logic               dbz_reg;
  logic [CNT_W-1:0]   count;

  logic [N:0]         a_nxt;
  logic [N-1:0]       q_nxt;

  div_step #(.N(N)) u_step (
    .a     (a_reg),
    .q     (q_reg),
    .m     (m_reg),
    .a_nxt (a_nxt),
    .q_nxt (q_nxt)
  );

  assign d_ready_data = (state == ST_IDLE) && ready_f_res;
  assign d_valid_res  = (state == ST_SAVE);
  // The remainder always ends below the divisor, so A's top bit is never exported.
  assign result_div   = {id_reg, dbz_reg, a_reg[N-1:0], q_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_reg   <= '0;
      q_reg   <= '0;
      m_reg   <= '0;
      id_reg  <= '0;
      dbz_reg <= 1'b0;
      count   <= '0;
      start   <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (d_valid_data && d_ready_data) begin
            q_reg   <= a_in;
            m_reg   <= b_in;
            a_reg   <= '0;
            id_reg  <= id_div;
            dbz_reg <= 1'b0;
            count   <= '0;
            start   <= 1'b1;
            state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // Divide by zero: quotient saturates to all ones, remainder is the dividend.
          if (m_reg == '0) begin
            dbz_reg <= 1'b1;
            a_reg   <= {1'b0, q_reg};
            q_reg   <= '1;
            state   <= ST_SAVE;
          end else begin
            state <= ST_ITER;
          end
        end
        ST_ITER: begin
          a_reg <= a_nxt;
          q_reg <= q_nxt;
          count <= count + 1'b1;
          if (count == CNT_W'(N - 1)) state <= ST_SAVE;
        end
        ST_SAVE: begin
          if (div_written) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_fsm.sv
// Self-checking bench for div_fsm: directed cases plus randomized operations
// compared against a plain-arithmetic division model.
module tb_div_fsm;

  localparam int N  = 8;
  localparam int RW = 2 * N + 1 + 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  a_in, b_in;
  logic [7:0]    id_div;
  logic          d_valid_data, ready_f_res, div_written;
  logic          d_ready_data, d_valid_res, start;
  logic [RW-1:0] result_div;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_fsm #(.DATA_SIZE(16), .DIV_DATA_SIZE(N), .ID_SIZE(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_in         (a_in),
    .b_in         (b_in),
    .id_div       (id_div),
    .d_valid_data (d_valid_data),
    .ready_f_res  (ready_f_res),
    .div_written  (div_written),
    .d_ready_data (d_ready_data),
    .d_valid_res  (d_valid_res),
    .result_div   (result_div),
    .start        (start)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] model(input int a, input int b, input int id);
    int q, r, dbz;
    if (b == 0) begin
      q = 255; r = a; dbz = 1;
    end else begin
      q = a / b; r = a % b; dbz = 0;
    end
    return {id[7:0], dbz[0], r[7:0], q[7:0]};
  endfunction

  // Entered and left at a falling edge; leaves the divider back in IDLE.
  task automatic run_op(input int a, input int b, input int id, input int hold);
    int k;
    int exp_lat;
    logic [RW-1:0] exp_res;
    exp_res = model(a, b, id);
    exp_lat = (b == 0) ? 2 : N + 2;
    a_in = a[N-1:0]; b_in = b[N-1:0]; id_div = id[7:0];
    d_valid_data = 1'b1; ready_f_res = 1'b1; div_written = 1'b0;
    #1 check("ready_idle", d_ready_data, 1);
    @(posedge clk); @(negedge clk);
    check("start_pulse", start, 1);
    // Busy period: offer junk operands that must be ignored.
    a_in = N'($urandom); b_in = N'($urandom); id_div = 8'($urandom);
    ready_f_res = 1'($urandom);
    k = 1;
    while (!d_valid_res && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, exp_lat);
    check("result", result_div, exp_res);
    check("ready_busy", d_ready_data, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", d_valid_res, 1);
      check("hold_result", result_div, exp_res);
    end
    d_valid_data = 1'b0; ready_f_res = 1'b1; div_written = 1'b1;
    @(posedge clk); @(negedge clk);
    div_written = 1'b0;
    check("released", d_valid_res, 0);
    check("kept_result", result_div, exp_res);
  endtask

  initial begin
    int seen;
    rst = 1'b1; a_in = '0; b_in = '0; id_div = '0;
    d_valid_data = 1'b0; ready_f_res = 1'b0; div_written = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_result", result_div, 0);
    check("rst_valid", d_valid_res, 0);
    check("rst_start", start, 0);
    check("rst_ready", d_ready_data, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(100, 7, 8'h3C, 0);
    run_op(255, 1, 8'h01, 0);
    run_op(5, 9, 8'h02, 0);
    run_op(0, 3, 8'h03, 0);
    run_op(42, 0, 8'h11, 0);

    // Result FIFO full: no accept may happen.
    a_in = 8'd9; b_in = 8'd2; id_div = 8'h44;
    d_valid_data = 1'b1; ready_f_res = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("blocked_ready", d_ready_data, 0);
      @(negedge clk);
      check("blocked_start", start, 0);
    end
    d_valid_data = 1'b0;
    run_op(9, 2, 8'h44, 5);

    // Reset during the fourth iteration discards the operation.
    a_in = 8'd77; b_in = 8'd5; id_div = 8'h55;
    d_valid_data = 1'b1; ready_f_res = 1'b1;
    @(posedge clk); @(negedge clk);
    d_valid_data = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", d_valid_res, 0);
    check("midrst_result", result_div, 0);
    check("midrst_start", start, 0);
    check("midrst_idle", d_ready_data, 1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (d_valid_res) seen++;
    end
    check("midrst_no_result", seen, 0);
    run_op(77, 5, 8'h56, 0);

    // Back-to-back operations with immediate release.
    run_op(200, 13, 8'hA0, 0);
    run_op(17, 17, 8'hA1, 0);

    for (int t = 0; t < 40; t++) begin
      int a, b;
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) begin
        d_valid_data = 1'b1; ready_f_res = 1'b0;
        #1 check("rnd_blocked", d_ready_data, 0);
        @(negedge clk);
        check("rnd_blocked_start", start, 0);
      end
      run_op(a, b, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) repeat (int'($urandom_range(1, 3))) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
